// File: rtl/text_pkg.sv
// Shared types and constants for the on-screen text slot scheduler.
package text_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    localparam logic [6:0] ASCII_BLANK = 7'h20;
    localparam logic [6:0] ASCII_ZERO  = 7'h30;

    typedef struct packed {
        logic       en;
        logic       page;
        logic [9:0] x;
        logic [9:0] y;
        logic [6:0] ascii;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COMMIT
    } state_t;

endpackage

// File: rtl/slot_match.sv
// Combinational priority matcher: finds the lowest-index enabled slot on the
// active page whose glyph box covers pixel (x, y).
module slot_match
    import text_pkg::*;
#(
    parameter int  NUM_SLOTS = 32,
    localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS*SLOT_W-1:0] table_i,
    input  logic [9:0]                  x_i,
    input  logic [9:0]                  y_i,
    input  logic                        page_i,
    output logic                        hit_o,
    output logic [IDX_W-1:0]            idx_o,
    output logic [3:0]                  row_o,
    output logic [2:0]                  col_o
);

    slot_t s;
    logic  in_x;
    logic  in_y;

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        row_o = '0;
        col_o = '0;
        s     = '0;
        in_x  = 1'b0;
        in_y  = 1'b0;
        // Walk downwards so the lowest matching index is the one left standing.
        // Bounds are compared in 11 bits so a slot near column 1023 cannot wrap.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            s    = slot_t'(table_i[i*SLOT_W +: SLOT_W]);
            in_x = ({1'b0, x_i} >= {1'b0, s.x}) &&
                   ({1'b0, x_i} <  ({1'b0, s.x} + 11'(CHAR_W)));
            in_y = ({1'b0, y_i} >= {1'b0, s.y}) &&
                   ({1'b0, y_i} <  ({1'b0, s.y} + 11'(CHAR_H)));
            if (s.en && (s.page == page_i) && in_x && in_y) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
                row_o = y_i[3:0] - s.y[3:0];
                col_o = x_i[2:0] - s.x[2:0];
            end
        end
    end

endmodule

// File: rtl/text_slot_scheduler.sv
// Double-buffered character slot table with frame-synchronous commit and a
// two-stage pixel lookup sharing one ascii_rom.
module text_slot_scheduler
    import text_pkg::*;
#(
    parameter int  NUM_SLOTS = 32,
    parameter int  VBLANK_Y  = 480,
    localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             video_on,
    input  logic             page_sel,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_slot,
    input  logic             cfg_en,
    input  logic             cfg_page,
    input  logic [9:0]       cfg_x,
    input  logic [9:0]       cfg_y,
    input  logic [6:0]       cfg_ascii,
    input  logic             commit_req,
    output logic             commit_done,
    output logic             busy,
    output logic [10:0]      rom_addr,
    input  logic [7:0]       rom_data,
    output logic             pix_on,
    output logic             video_on_d
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    slot_t shadow_q [NUM_SLOTS];
    slot_t active_q [NUM_SLOTS];
    slot_t wr_slot;

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             page_active_q, page_active_d;
    logic             frame_bnd;

    logic [NUM_SLOTS*SLOT_W-1:0] active_flat;
    logic                        m_hit;
    logic [IDX_W-1:0]            m_idx;
    logic [3:0]                  m_row;
    logic [2:0]                  m_col;
    logic [10:0]                 rom_addr_d;

    logic        hit_p1_q, vld_p1_q, hit_p2_q, vld_p2_q;
    logic [2:0]  col_p1_q, col_p2_q;
    logic [10:0] rom_addr_q;

    assign frame_bnd = (y == 10'(VBLANK_Y)) && (x == 10'd0);
    assign cfg_ready = (state_q != COMMIT);
    assign busy      = pending_q || (state_q == COMMIT);

    assign wr_slot = '{en: cfg_en, page: cfg_page, x: cfg_x, y: cfg_y, ascii: cfg_ascii};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (cfg_valid && cfg_ready) begin
                shadow_q[cfg_slot] <= wr_slot;
            end
            if (state_q == COMMIT) begin
                active_q[idx_q] <= shadow_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            idx_q         <= '0;
            page_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            idx_q         <= idx_d;
            page_active_q <= page_active_d;
        end
    end

    // pending drops on entering COMMIT so that a request arriving mid-copy
    // is remembered and triggers another commit at the following frame.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        idx_d         = idx_q;
        page_active_d = page_active_q;
        commit_done   = 1'b0;
        if (frame_bnd) begin
            page_active_d = page_sel;
        end
        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    pending_d = 1'b1;
                    state_d   = ARMED;
                end
            end
            ARMED: begin
                if (frame_bnd) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = COMMIT;
                end
            end
            COMMIT: begin
                idx_d = idx_q + 1'b1;
                if (commit_req) begin
                    pending_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    commit_done = 1'b1;
                    state_d     = (pending_q || commit_req) ? ARMED : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        active_flat = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            active_flat[i*SLOT_W +: SLOT_W] = active_q[i];
        end
    end

    slot_match #(
        .NUM_SLOTS(NUM_SLOTS)
    ) u_match (
        .table_i(active_flat),
        .x_i    (x),
        .y_i    (y),
        .page_i (page_active_q),
        .hit_o  (m_hit),
        .idx_o  (m_idx),
        .row_o  (m_row),
        .col_o  (m_col)
    );

    assign rom_addr_d = m_hit ? {active_q[m_idx].ascii, m_row} : {ASCII_BLANK, 4'h0};

    // Stage 1: ROM address issued; Stage 2: glyph row returns from the ROM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_p1_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
            rom_addr_q <= '0;
            hit_p2_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
        end else begin
            hit_p1_q   <= m_hit;
            vld_p1_q   <= video_on;
            rom_addr_q <= rom_addr_d;
            hit_p2_q   <= hit_p1_q;
            vld_p2_q   <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        col_p1_q <= m_col;
        col_p2_q <= col_p1_q;
    end

    assign rom_addr   = rom_addr_q;
    assign pix_on     = hit_p2_q && vld_p2_q && rom_data[3'd7 - col_p2_q];
    assign video_on_d = vld_p2_q;

endmodule
